mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 30 +++
 rtl/mult_div_unit_datapath.sv | 115 +++++++++++
 rtl/mult_div_unit.sv | 121 ++++++++++++
 tb/tb_mult_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states,
// iteration count and small op-decoding helpers.
package mult_div_unit_pkg;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_datapath.sv
// Iterative datapath: radix-2 shift-add multiply, restoring divide and the
// final sign fix. Sequencing (load/step/fix) comes from mult_div_unit.
module md_datapath
  import mult_div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  md_op_e       i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_step,
  input  logic         i_fix,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo,
  output logic         o_dbz
);

  logic           r_div;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dbz;
  logic [W-1:0]   r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;

  logic           w_sgn;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic [W:0]     w_sum;
  logic [W:0]     w_shift;
  logic [W:0]     w_trial;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_quo_fix;
  logic [W-1:0]   w_rem_fix;

  always_comb begin
    w_sgn   = op_is_signed(i_op);
    w_mag_a = (w_sgn && i_a[W-1]) ? -i_a : i_a;
    w_mag_b = (w_sgn && i_b[W-1]) ? -i_b : i_b;
  end

  // Multiply: add multiplicand into the upper half when the LSB of the
  // multiplier (low half of r_acc) is set, then shift the whole thing right.
  always_comb begin
    w_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  end

  // Divide: shift the next dividend bit into the 33-bit partial remainder and
  // keep the difference only when it does not go negative.
  always_comb begin
    w_shift = {r_rem, r_acc[W-1]};
    w_trial = w_shift - {1'b0, r_mcand};
  end

  always_comb begin
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    w_quo      = r_acc[W-1:0];
    w_quo_fix  = r_dbz ? '1 : (r_neg_q ? -w_quo : w_quo);
    w_rem_fix  = r_neg_r ? -r_rem : r_rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_load) begin
      r_div   <= op_is_div(i_op);
      r_neg_q <= w_sgn & (i_a[W-1] ^ i_b[W-1]);
      r_neg_r <= w_sgn & i_a[W-1];
      r_dbz   <= op_is_div(i_op) & (i_b == '0);
      r_mcand <= w_mag_b;
      r_acc   <= {{W{1'b0}}, w_mag_a};
      r_rem   <= '0;
    end else if (i_step) begin
      if (r_div) begin
        if (w_trial[W]) begin
          r_rem <= w_shift[W-1:0];
          r_acc <= {r_acc[2*W-1:W], r_acc[W-2:0], 1'b0};
        end else begin
          r_rem <= w_trial[W-1:0];
          r_acc <= {r_acc[2*W-1:W], r_acc[W-2:0], 1'b1};
        end
      end else begin
        r_acc <= {w_sum, r_acc[W-1:1]};
      end
    end else if (i_fix) begin
      if (r_div) begin
        // A zero divisor leaves |a| as remainder; the sign fix restores a.
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        r_hi <= w_prod_fix[2*W-1:W];
        r_lo <= w_prod_fix[W-1:0];
      end
    end
  end

  assign o_hi  = r_hi;
  assign o_lo  = r_lo;
  assign o_dbz = r_dbz;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: FSM, iteration counter and the
// architectural HI/LO registers around the iterative md_datapath.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  md_state_e             r_state;
  md_state_e             w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic                  r_done;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_step;
  logic                  w_fix;
  logic                  w_idle;
  logic [DATA_WIDTH-1:0] w_dp_hi;
  logic [DATA_WIDTH-1:0] w_dp_lo;
  logic                  w_dp_dbz;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(ITERATIONS - 1)) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_idle = (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset)         r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (w_step)   r_cnt <= r_cnt + 1'b1;
  end

  // MTHI/MTLO only land in IDLE; a start in the same cycle is still accepted
  // and its result overwrites the write in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      r_dbz  <= (r_state == ST_DONE) & w_dp_dbz;
      if (r_state == ST_DONE) begin
        r_hi <= w_dp_hi;
        r_lo <= w_dp_lo;
      end else if (w_idle) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  md_datapath #(
    .W (DATA_WIDTH)
  ) u_dp (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_op   (md_op_e'(op)),
    .i_a    (data_a),
    .i_b    (data_b),
    .i_step (w_step),
    .i_fix  (w_fix),
    .o_hi   (w_dp_hi),
    .o_lo   (w_dp_lo),
    .o_dbz  (w_dp_dbz)
  );

  assign busy        = ~w_idle;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/flag and done cycle are
// queued at issue and checked whenever done pulses.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] data_a, data_b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .data_a(data_a), .data_b(data_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t q_exp[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q_exp.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        m_e = q_exp.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, m_e.hi});
        chk("lo", {32'b0, lo}, {32'b0, m_e.lo});
        chk("dbz", {63'b0, div_by_zero}, {63'b0, m_e.dbz});
        chk("latency", 64'(cyc), 64'(m_e.cyc));
      end
    end else if (div_by_zero !== 1'b0) begin
      chk("dbz_outside_done", {63'b0, div_by_zero}, 64'd0);
    end
  end

  // Called at a negedge: the start edge makes cyc+1, done lands 34 edges later.
  task automatic push(input logic [31:0] eh, input logic [31:0] el, input logic ed);
    q_exp.push_back('{hi: eh, lo: el, dbz: ed, cyc: cyc + 35});
  endtask

  task automatic kick(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; data_a = a; data_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
    else begin
      @(negedge clk);
      chk("done_pulse_width", {63'b0, done}, 64'd0);
      chk("busy_after_done", {63'b0, busy}, 64'd0);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic ed);
    push(eh, el, ed);
    kick(o, a, b);
    wait_done();
  endtask

  // Reference from native 64-bit arithmetic: {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sbv; return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sbv; r = sa % sbv;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = longint'({32'b0, a}) / longint'({32'b0, b});
        r = longint'({32'b0, a}) % longint'({32'b0, b});
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [64:0] m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          seen;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; data_a = '0; data_b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run(MD_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run(MD_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1);
    run(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run(MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // start + MTHI mid-operation must be ignored
    push(32'd0, 32'd12, 1'b0);
    kick(MD_MULTU, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    op = MD_DIV; data_a = 32'd100; data_b = 32'd7;
    start = 1'b1; hi_we = 1'b1; wdata = 32'h1234;
    chk("busy_mid_op", {63'b0, busy}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0; hi_we = 1'b0;
    chk("hi_hold_while_busy", {32'b0, hi}, 64'h0000_0000_FFFF_FFF9);
    wait_done();

    // MTHI in IDLE
    hi_we = 1'b1; wdata = 32'h5555;
    @(posedge clk);
    #1 hi_we = 1'b0;
    chk("mthi_idle", {32'b0, hi}, 64'h5555);
    chk("mthi_lo_kept", {32'b0, lo}, 64'd12);

    // MTLO together with start: write lands, result overwrites later
    @(negedge clk);
    push(32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0);
    lo_we = 1'b1; wdata = 32'h77;
    kick(MD_MULT, 32'd5, 32'hFFFF_FFFE);
    lo_we = 1'b0;
    chk("mtlo_with_start", {32'b0, lo}, 64'h77);
    chk("busy_after_accept", {63'b0, busy}, 64'd1);
    wait_done();

    // reset at N+20 of a DIVU aborts with no done pulse
    kick(MD_DIVU, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_hi", {32'b0, hi}, 64'd0);
    chk("abort_lo", {32'b0, lo}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    lo_we = 1'b1; wdata = 32'hABCD;
    @(posedge clk);
    #1 lo_we = 1'b0;
    chk("mtlo_after_abort", {32'b0, lo}, 64'hABCD);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (ro[1] && $urandom_range(0, 1) == 1) rb = $urandom_range(1, 100);
      if (rb == 0) rb = 32'd1;
      m = model(ro, ra, rb);
      run(ro, ra, rb, m[63:32], m[31:0], m[64]);
    end

    chk("scoreboard_empty", 64'(q_exp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
